rv0_wb_arb: RTL and testbench

Integer register write-back arbiter. It shares the single integer register file write port among `REQ_CNT` execution-unit result sources. Selection is round-robin, and the winning result is registered onto the write-back interface that feeds the register file and the decode-stage reservation counters. It sits between the execution units' result outputs and the integer `rv_rwb_if` sink of the decode unit.

---
 rtl/rv0_wb_arb.sv | 128 ++++++++++++
 tb/tb_rv0_wb_arb.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rv0_wb_arb.sv
// Integer register write-back arbiter: round-robin selection among REQ_CNT result
// sources, winning result registered onto the register file write port.
module rv0_wb_arb #(
    parameter int unsigned XLEN    = 32,
    parameter int unsigned REQ_CNT = 4,
    parameter int unsigned REG_AW  = 5
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      flush_i,
    input  logic [REQ_CNT-1:0]        req_vld_i,
    input  logic [REQ_CNT*REG_AW-1:0] req_waddr_i,
    input  logic [REQ_CNT*XLEN-1:0]   req_wdata_i,
    output logic [REQ_CNT-1:0]        req_rdy_o,
    output logic                      we_o,
    output logic [REG_AW-1:0]         waddr_o,
    output logic [XLEN-1:0]           wdata_o,
    output logic [REQ_CNT*16-1:0]     gnt_cnt_o
);

    localparam int unsigned     PtrW    = (REQ_CNT > 1) ? $clog2(REQ_CNT) : 1;
    localparam logic [PtrW-1:0] LastIdx = PtrW'(REQ_CNT - 1);

    logic [PtrW-1:0]   ptr_q, ptr_d;
    logic [PtrW-1:0]   win_idx;
    logic              win_found;
    logic [REQ_CNT-1:0] gnt;
    logic              xfer;
    logic [REG_AW-1:0] sel_waddr;
    logic [XLEN-1:0]   sel_wdata;

    logic              we_q, we_d;
    logic [REG_AW-1:0] waddr_q, waddr_d;
    logic [XLEN-1:0]   wdata_q, wdata_d;
    logic [15:0]       cnt_q [REQ_CNT];
    logic [15:0]       cnt_d [REQ_CNT];

    // Round-robin search: first valid index starting at ptr_q, wrapping modulo REQ_CNT.
    always_comb begin
        int unsigned     idx;
        logic [PtrW-1:0] cand;
        idx       = 0;
        cand      = '0;
        win_idx   = '0;
        win_found = 1'b0;
        for (int unsigned k = 0; k < REQ_CNT; k++) begin
            idx  = (32'(ptr_q) + k) % REQ_CNT;
            cand = idx[PtrW-1:0];
            if (!win_found && req_vld_i[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    // Grant is suppressed during reset and flush; flush outranks any request.
    always_comb begin
        gnt = '0;
        if (rst_ni && !flush_i && win_found) begin
            gnt[win_idx] = 1'b1;
        end
    end

    assign req_rdy_o = gnt;
    assign xfer      = |gnt;

    // Winner's address/data mux.
    always_comb begin
        sel_waddr = '0;
        sel_wdata = '0;
        for (int unsigned i = 0; i < REQ_CNT; i++) begin
            if (gnt[i]) begin
                sel_waddr = req_waddr_i[i*REG_AW +: REG_AW];
                sel_wdata = req_wdata_i[i*XLEN +: XLEN];
            end
        end
    end

    // Next-state: pointer, output register and grant counters.
    always_comb begin
        ptr_d   = ptr_q;
        we_d    = 1'b0;
        waddr_d = waddr_q;
        wdata_d = wdata_q;
        if (flush_i) begin
            ptr_d = '0;
        end else if (xfer) begin
            ptr_d   = (win_idx == LastIdx) ? '0 : win_idx + PtrW'(1);
            // x0 writes consume the grant but never assert the write enable
            we_d    = |sel_waddr;
            waddr_d = sel_waddr;
            wdata_d = sel_wdata;
        end
        for (int unsigned i = 0; i < REQ_CNT; i++) begin
            cnt_d[i] = cnt_q[i] + (gnt[i] ? 16'd1 : 16'd0);
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            ptr_q   <= '0;
            we_q    <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
            for (int unsigned i = 0; i < REQ_CNT; i++) begin
                cnt_q[i] <= 16'd0;
            end
        end else begin
            ptr_q   <= ptr_d;
            we_q    <= we_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
            for (int unsigned i = 0; i < REQ_CNT; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign we_o    = we_q;
    assign waddr_o = waddr_q;
    assign wdata_o = wdata_q;

    for (genvar g = 0; g < REQ_CNT; g++) begin : g_cnt_out
        assign gnt_cnt_o[g*16 +: 16] = cnt_q[g];
    end

endmodule

// File: tb/tb_rv0_wb_arb.sv
// Self-checking bench for rv0_wb_arb: directed scenarios with literal expectations,
// then randomized traffic checked every cycle against a behavioural model.
module tb_rv0_wb_arb;
    localparam int N  = 4;
    localparam int AW = 5;
    localparam int XL = 32;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            flush;
    logic [N-1:0]    vld;
    logic [N*AW-1:0] waddr;
    logic [N*XL-1:0] wdata;
    logic [N-1:0]    rdy;
    logic            we;
    logic [AW-1:0]   waddr_o;
    logic [XL-1:0]   wdata_o;
    logic [N*16-1:0] cnt_o;

    int errors = 0;
    int checks = 0;

    rv0_wb_arb #(.XLEN(XL), .REQ_CNT(N), .REG_AW(AW)) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .flush_i     (flush),
        .req_vld_i   (vld),
        .req_waddr_i (waddr),
        .req_wdata_i (wdata),
        .req_rdy_o   (rdy),
        .we_o        (we),
        .waddr_o     (waddr_o),
        .wdata_o     (wdata_o),
        .gnt_cnt_o   (cnt_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    function automatic int winner(input logic [N-1:0] v, input int p);
        logic [N-1:0] t;
        for (int k = 0; k < N; k++) begin
            t = v >> ((p + k) % N);
            if (t[0]) return (p + k) % N;
        end
        return -1;
    endfunction

    function automatic logic [AW-1:0] addr_of(input int i);
        return AW'(waddr >> (i * AW));
    endfunction

    function automatic logic [XL-1:0] data_of(input int i);
        return XL'(wdata >> (i * XL));
    endfunction

    int            m_ptr = 0;
    logic          m_we = 1'b0;
    logic [AW-1:0] m_waddr = '0;
    logic [XL-1:0] m_wdata = '0;
    int            m_cnt [N];
    int            m_win;
    bit            chk_en = 1'b0;

    always_comb m_win = winner(vld, m_ptr);

    always @(posedge clk) begin
        if (!rst_n) begin
            m_we    <= 1'b0;
            m_waddr <= '0;
            m_wdata <= '0;
            m_ptr   <= 0;
            for (int i = 0; i < N; i++) m_cnt[i] <= 0;
            chk_en  <= 1'b1;
        end else if (flush) begin
            m_we  <= 1'b0;
            m_ptr <= 0;
        end else if (m_win >= 0) begin
            m_we         <= (addr_of(m_win) != 0);
            m_waddr      <= addr_of(m_win);
            m_wdata      <= data_of(m_win);
            m_ptr        <= (m_win + 1) % N;
            m_cnt[m_win] <= (m_cnt[m_win] + 1) % 65536;
        end else begin
            m_we <= 1'b0;
        end
    end

    // ---------------- per-cycle compare ----------------
    logic [N-1:0]    prev_pend = '0;
    logic [N*AW-1:0] prev_addr;
    logic [N*XL-1:0] prev_data;
    logic [N-1:0]    prev_rdy = '0;

    always @(negedge clk) begin
        logic [N-1:0] exp_rdy;
        if (chk_en) begin
            exp_rdy = '0;
            if (rst_n && !flush && m_win >= 0) exp_rdy = N'(1) << m_win;
            check("rdy", 64'(rdy), 64'(exp_rdy));
            check("we", 64'(we), 64'(m_we));
            check("waddr", 64'(waddr_o), 64'(m_waddr));
            check("wdata", 64'(wdata_o), 64'(m_wdata));
            for (int i = 0; i < N; i++) begin
                check($sformatf("cnt%0d", i), 64'(cnt_o[i*16 +: 16]), 64'(m_cnt[i]));
            end
            // Requester rule: pending requests hold valid, address and data
            for (int i = 0; i < N; i++) begin
                if (prev_pend[i]) begin
                    check($sformatf("hold_vld%0d", i), 64'(vld[i]), 64'd1);
                    check($sformatf("hold_addr%0d", i), 64'(waddr[i*AW +: AW]),
                          64'(prev_addr[i*AW +: AW]));
                    check($sformatf("hold_data%0d", i), 64'(wdata[i*XL +: XL]),
                          64'(prev_data[i*XL +: XL]));
                end
            end
            // Nobody is granted twice in a row while another requester waits
            if (prev_rdy != 0 && rdy != 0 && (vld & ~prev_rdy) != 0) begin
                check("no_repeat", 64'(rdy == prev_rdy), 64'd0);
            end
            prev_pend = vld & ~rdy;
            prev_addr = waddr;
            prev_data = wdata;
            prev_rdy  = rdy;
        end
    end

    // ---------------- stimulus ----------------
    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    task automatic set_req(input int i, input logic [AW-1:0] a, input logic [XL-1:0] d);
        waddr[i*AW +: AW] = a;
        wdata[i*XL +: XL] = d;
    endtask

    initial begin
        int           wait_cnt;
        bit           got3;
        logic [N-1:0] acc;

        rst_n = 1'b0;
        flush = 1'b0;
        vld   = '0;
        waddr = '0;
        wdata = '0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Single request from requester 2
        set_req(2, 5'd5, 32'hDEADBEEF);
        vld = 4'b0100;
        smp();
        check("t1_rdy", 64'(rdy), 64'h4);
        check("t1_we_idle", 64'(we), 64'd0);
        nxt();
        vld = '0;
        smp();
        check("t1_we", 64'(we), 64'd1);
        check("t1_waddr", 64'(waddr_o), 64'd5);
        check("t1_wdata", 64'(wdata_o), 64'hDEADBEEF);
        nxt();
        smp();
        check("t1_we_low", 64'(we), 64'd0);
        check("t1_cnt2", 64'(cnt_o[2*16 +: 16]), 64'd1);

        // Idle flush brings the pointer back to 0
        nxt();
        flush = 1'b1;
        nxt();
        flush = 1'b0;

        // Round-robin: all valid, each requester re-issues once then drops
        for (int i = 0; i < N; i++) set_req(i, AW'(i + 10), 32'h1000 + i);
        vld = 4'b1111;
        for (int c = 0; c < 8; c++) begin
            smp();
            check($sformatf("rr_rdy%0d", c), 64'(rdy), 64'(1) << (c % 4));
            if (c > 0) check($sformatf("rr_we%0d", c), 64'(we), 64'd1);
            nxt();
            if (c >= 4) vld[c % 4] = 1'b0;
            else set_req(c % 4, AW'(c + 20), 32'h2000 + c);
        end
        smp();
        check("rr_we_last", 64'(we), 64'd1);
        check("rr_wdata_last", 64'(wdata_o), 64'h2003);
        check("rr_cnt0", 64'(cnt_o[0 +: 16]), 64'd2);
        check("rr_cnt1", 64'(cnt_o[16 +: 16]), 64'd2);
        check("rr_cnt2", 64'(cnt_o[32 +: 16]), 64'd3);
        check("rr_cnt3", 64'(cnt_o[48 +: 16]), 64'd2);

        // x0 write: accepted and counted, no write enable
        nxt();
        set_req(1, 5'd0, 32'h1);
        vld = 4'b0010;
        smp();
        check("x0_rdy", 64'(rdy), 64'h2);
        nxt();
        vld = '0;
        smp();
        check("x0_we", 64'(we), 64'd0);
        check("x0_cnt1", 64'(cnt_o[16 +: 16]), 64'd3);

        // Flush interaction
        nxt();
        set_req(0, 5'd7, 32'h0A0A0A0A);
        vld = 4'b0001;
        smp();
        check("fl_rdy_n", 64'(rdy), 64'h1);
        nxt();
        set_req(3, 5'd9, 32'h3333);
        vld   = 4'b1000;
        flush = 1'b1;
        smp();
        check("fl_we_n1", 64'(we), 64'd1);
        check("fl_waddr_n1", 64'(waddr_o), 64'd7);
        check("fl_rdy_n1", 64'(rdy), 64'h0);
        nxt();
        flush = 1'b0;
        smp();
        check("fl_we_n2", 64'(we), 64'd0);
        check("fl_rdy_n2", 64'(rdy), 64'h8);
        nxt();
        vld = '0;

        // Reset in the cycle after a grant
        set_req(1, 5'd3, 32'h5555);
        vld = 4'b0010;
        smp();
        check("rs_rdy", 64'(rdy), 64'h2);
        nxt();
        vld   = '0;
        rst_n = 1'b0;
        smp();
        check("rs_rdy_in_reset", 64'(rdy), 64'h0);
        nxt();
        rst_n = 1'b1;
        set_req(0, 5'd4, 32'h4444);
        set_req(3, 5'd6, 32'h6666);
        vld = 4'b1001;
        smp();
        check("rs_we", 64'(we), 64'd0);
        check("rs_waddr", 64'(waddr_o), 64'd0);
        check("rs_wdata", 64'(wdata_o), 64'd0);
        check("rs_cnts", 64'(cnt_o), 64'd0);
        check("rs_first", 64'(rdy), 64'h1);
        nxt();
        vld = 4'b1000;
        smp();
        check("rs_second", 64'(rdy), 64'h8);
        nxt();
        vld = '0;

        // Starvation: requester 0 always valid, requester 3 joins at cycle 10
        set_req(0, 5'd1, 32'h100);
        vld      = 4'b0001;
        wait_cnt = 0;
        got3     = 1'b0;
        for (int c = 0; c < 40; c++) begin
            if (c == 10) begin
                set_req(3, 5'd2, 32'h300);
                vld[3] = 1'b1;
            end
            smp();
            acc = vld & rdy;
            if (vld[3] && !acc[3] && !got3) wait_cnt++;
            if (acc[3]) got3 = 1'b1;
            nxt();
            if (acc[3]) vld[3] = 1'b0;
            if (acc[0]) begin
                if (c >= 19) vld[0] = 1'b0;
                else set_req(0, AW'(c % 31 + 1), 32'h100 + c);
            end
            if (vld == 0) break;
        end
        check("starve_granted", 64'(got3), 64'd1);
        check("starve_wait_le3", 64'(wait_cnt <= 3), 64'd1);
        check("starve_drained", 64'(vld), 64'd0);

        // Randomized traffic against the model
        acc = '0;
        for (int c = 0; c < 3000; c++) begin
            smp();
            acc = vld & rdy;
            nxt();
            for (int i = 0; i < N; i++) begin
                if (!(vld[i] && !acc[i])) begin
                    vld[i] = ($urandom_range(0, 99) < 50);
                    if (vld[i]) begin
                        set_req(i, ($urandom_range(0, 7) == 0) ? AW'(0) : AW'($urandom),
                                $urandom);
                    end
                end
            end
            flush = ($urandom_range(0, 99) < 6);
            rst_n = ($urandom_range(0, 199) != 0);
        end
        nxt();
        flush = 1'b0;
        rst_n = 1'b1;
        repeat (3) nxt();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
